// File: rtl/vend_pkg.sv
// vend_pkg: shared state encoding and dispense status codes for the vending front-ends and motor arbiter
package vend_pkg;
  localparam int ST_W = 3;
  typedef enum logic [ST_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_WAIT_DROP = 3'd2,
    ST_DONE      = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;
  typedef enum logic [1:0] {
    STAT_NONE   = 2'd0,
    STAT_DONE   = 2'd1,
    STAT_RETURN = 2'd2
  } status_t;
endpackage

// File: rtl/vend_rr_picker.sv
// vend_rr_picker: combinational round-robin picker returning the first set req bit at or after rr_ptr
module vend_rr_picker #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] rr_ptr,
  output logic          any,
  output logic [PW-1:0] idx
);
  always_comb begin
    any = |req;
    idx = rr_ptr;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[PW'((int'(rr_ptr) + i) % N)]) idx = PW'((int'(rr_ptr) + i) % N);
    end
  end
endmodule

// File: rtl/vend_dispense_arbiter.sv
// vend_dispense_arbiter: round-robin arbiter sharing one dispense motor with drop-sensor done/fault reporting
module vend_dispense_arbiter
  import vend_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int RUN_CYCLES   = 8,
  parameter int DROP_TIMEOUT = 16,
  parameter int CNT_W        = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               drop_sensed,
  output logic [NUM_REQ-1:0] grant,
  output logic               motor_on,
  output logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] fault,
  output logic               busy
);
  localparam int PW = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] RUN_LD  = CNT_W'(RUN_CYCLES - 1);
  localparam logic [CNT_W-1:0] DROP_LD = CNT_W'(DROP_TIMEOUT - 1);
  state_t           state;
  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    idx;
  logic [PW-1:0]    pick;
  logic             any;
  logic [CNT_W-1:0] timer;
  logic             seen;
  vend_rr_picker #(.N(NUM_REQ), .PW(PW)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .any    (any),
    .idx    (pick)
  );
  assign busy = state != ST_IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      grant    <= '0;
      motor_on <= 1'b0;
      done     <= '0;
      fault    <= '0;
      rr_ptr   <= '0;
      idx      <= '0;
      timer    <= '0;
      seen     <= 1'b0;
    end else begin
      done  <= '0;
      fault <= '0;
      case (state)
        ST_IDLE: if (any) begin
          idx      <= pick;
          grant    <= NUM_REQ'(1) << pick;
          motor_on <= 1'b1;
          timer    <= RUN_LD;
          seen     <= 1'b0;
          state    <= ST_RUN;
        end
        ST_RUN: if (timer == '0) begin
          motor_on <= 1'b0;
          timer    <= seen || drop_sensed ? timer : DROP_LD;
          state    <= seen || drop_sensed ? ST_DONE : ST_WAIT_DROP;
        end else begin
          timer <= timer - 1'b1;
          seen  <= seen | drop_sensed;
        end
        ST_WAIT_DROP: begin
          state <= drop_sensed ? ST_DONE : timer == '0 ? ST_FAULT : ST_WAIT_DROP;
          timer <= drop_sensed || timer == '0 ? timer : timer - 1'b1;
        end
        ST_DONE, ST_FAULT: begin
          done   <= state == ST_DONE ? grant : '0;
          fault  <= state == ST_FAULT ? grant : '0;
          grant  <= '0;
          rr_ptr <= idx == PW'(NUM_REQ - 1) ? '0 : idx + 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vend_dispense_arbiter.sv
// tb_vend_dispense_arbiter: directed self-checking bench for the dispense motor arbiter
module tb_vend_dispense_arbiter;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = '0;
  logic       drop_sensed = 1'b0;
  logic [3:0] grant;
  logic       motor_on;
  logic [3:0] done;
  logic [3:0] fault;
  logic       busy;
  int n_chk = 0;
  int n_pass = 0;
  logic [3:0] order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  vend_dispense_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .drop_sensed (drop_sensed),
    .grant       (grant),
    .motor_on    (motor_on),
    .done        (done),
    .fault       (fault),
    .busy        (busy)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask
  task automatic idle_outputs(input string tag);
    check({tag, "_grant"}, 32'(grant), 0);
    check({tag, "_motor"}, 32'(motor_on), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_fault"}, 32'(fault), 0);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask
  initial begin
    @(negedge clk);
    step();
    reset = 1'b0;
    idle_outputs("rst");
    req = 4'b0010;
    step();
    check("t1_grant", 32'(grant), 32'b0010);
    check("t1_motor_on", 32'(motor_on), 1);
    check("t1_busy", 32'(busy), 1);
    repeat (7) step();
    check("t1_motor_8th", 32'(motor_on), 1);
    step();
    check("t1_motor_off", 32'(motor_on), 0);
    check("t1_grant_wait", 32'(grant), 32'b0010);
    step();
    check("t1_no_early_done", 32'(done), 0);
    drop_sensed = 1'b1;
    step();
    drop_sensed = 1'b0;
    check("t1_done_pending", 32'(done), 0);
    step();
    check("t1_done", 32'(done), 32'b0010);
    check("t1_grant_clr", 32'(grant), 0);
    req = 4'b0000;
    step();
    idle_outputs("t1_end");
    reset = 1'b1;
    step();
    reset = 1'b0;
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      step();
      check("t2_grant", 32'(grant), 32'(order[g]));
      drop_sensed = 1'b1;
      step();
      drop_sensed = 1'b0;
      repeat (6) step();
      check("t2_motor_last", 32'(motor_on), 1);
      step();
      check("t2_motor_off", 32'(motor_on), 0);
      check("t2_grant_hold", 32'(grant), 32'(order[g]));
      step();
      check("t2_done", 32'(done), 32'(order[g]));
      check("t2_gap", 32'(grant), 0);
    end
    req = 4'b0100;
    step();
    check("t3_grant", 32'(grant), 32'b0100);
    repeat (7) step();
    check("t3_motor_last", 32'(motor_on), 1);
    step();
    check("t3_motor_off", 32'(motor_on), 0);
    repeat (16) step();
    check("t3_no_fault_yet", 32'(fault), 0);
    check("t3_grant_hold", 32'(grant), 32'b0100);
    step();
    check("t3_fault", 32'(fault), 32'b0100);
    check("t3_no_done", 32'(done), 0);
    req = 4'b0000;
    step();
    idle_outputs("t3_end");
    req = 4'b0001;
    step();
    check("t4_grant_wrap", 32'(grant), 32'b0001);
    step();
    drop_sensed = 1'b1;
    step();
    drop_sensed = 1'b0;
    repeat (6) step();
    check("t4_motor_off", 32'(motor_on), 0);
    check("t4_skip_wait", 32'(done), 0);
    step();
    check("t4_done", 32'(done), 32'b0001);
    req = 4'b0100;
    step();
    step();
    check("t5_grant", 32'(grant), 32'b0100);
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle_outputs("t5_rst");
    req = 4'b1001;
    step();
    check("t5_rr_cleared", 32'(grant), 32'b0001);
    drop_sensed = 1'b1;
    step();
    drop_sensed = 1'b0;
    repeat (7) step();
    step();
    check("t5_done", 32'(done), 32'b0001);
    step();
    check("t6_no_repeat", 32'(grant), 32'b1000);
    drop_sensed = 1'b1;
    step();
    drop_sensed = 1'b0;
    step();
    req = 4'b0001;
    repeat (6) step();
    check("t6_motor_off", 32'(motor_on), 0);
    step();
    check("t6_done_dropped_req", 32'(done), 32'b1000);
    step();
    check("t6_next_grant", 32'(grant), 32'b0001);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
